div_unit: RTL and testbench



---
 rtl/mips_pkg.sv | 18 +
 rtl/div_step.sv | 28 ++
 rtl/div_unit.sv | 112 +++++++++++
 tb/tb_div_unit.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS32 execute-stage definitions: divider FSM states, HI/LO sizing and
// the SPECIAL funct codes EX decode uses to start the divider.
package mips_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StDivZero,
    StBusy,
    StDone
  } div_state_t;

  localparam int unsigned DIV_CYCLES = 32;
  localparam int unsigned HILO_W     = 64;

  localparam logic [5:0] FUNCT_DIV  = 6'b011010;
  localparam logic [5:0] FUNCT_DIVU = 6'b011011;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step on the {rem, quot} partial register.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [2*WIDTH:0] partial,
  input  logic [WIDTH-1:0] divisor,
  output logic [2*WIDTH:0] partial_next
);

  logic [2*WIDTH:0] shifted;
  logic [WIDTH:0]   rem;
  logic [WIDTH:0]   diff;
  // The remainder always stays below the divisor, so the top bit is shifted out as zero.
  logic             unused_top;

  assign unused_top = partial[2*WIDTH];
  assign shifted    = {partial[2*WIDTH-1:0], 1'b0};
  assign rem        = shifted[2*WIDTH:WIDTH];
  assign diff       = rem - {1'b0, divisor};

  always_comb begin
    partial_next = shifted;
    if (rem >= {1'b0, divisor}) begin
      partial_next = {diff, shifted[WIDTH-1:1], 1'b1};
    end
  end

endmodule

// File: rtl/div_unit.sv
// Iterative DIV/DIVU unit feeding HI/LO: 32 restoring steps on magnitudes,
// then sign fixup of quotient and remainder into a registered result.
module div_unit
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              signed_div_i,
  input  logic [WIDTH-1:0]  opdata1_i,
  input  logic [WIDTH-1:0]  opdata2_i,
  input  logic              annul_i,
  output logic [HILO_W-1:0] result_o,
  output logic              ready_o
);

  localparam int unsigned CntW = $clog2(DIV_CYCLES);

  div_state_t        state_q;
  logic [CntW-1:0]   cnt_q;
  logic [2*WIDTH:0]  part_q;
  logic [2*WIDTH:0]  part_next;
  logic [WIDTH-1:0]  divisor_q;
  logic              neg_quot_q;
  logic              neg_rem_q;
  logic [HILO_W-1:0] result_q;
  logic              ready_q;

  logic [WIDTH-1:0]  abs_dividend;
  logic [WIDTH-1:0]  abs_divisor;
  logic [WIDTH-1:0]  quot_fix;
  logic [WIDTH-1:0]  rem_fix;

  div_step #(
    .WIDTH(WIDTH)
  ) u_div_step (
    .partial     (part_q),
    .divisor     (divisor_q),
    .partial_next(part_next)
  );

  always_comb begin
    abs_dividend = opdata1_i;
    abs_divisor  = opdata2_i;
    if (signed_div_i && opdata1_i[WIDTH-1]) abs_dividend = -opdata1_i;
    if (signed_div_i && opdata2_i[WIDTH-1]) abs_divisor = -opdata2_i;
    // Fixup uses the final step's output so the result lands with ready.
    quot_fix = part_next[WIDTH-1:0];
    rem_fix  = part_next[2*WIDTH-1:WIDTH];
    if (neg_quot_q) quot_fix = -part_next[WIDTH-1:0];
    if (neg_rem_q) rem_fix = -part_next[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      part_q     <= '0;
      divisor_q  <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      result_q   <= '0;
      ready_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_i && !annul_i) begin
            neg_quot_q <= signed_div_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
            neg_rem_q  <= signed_div_i & opdata1_i[WIDTH-1];
            divisor_q  <= abs_divisor;
            part_q     <= {{(WIDTH + 1){1'b0}}, abs_dividend};
            cnt_q      <= '0;
            state_q    <= (opdata2_i == '0) ? StDivZero : StBusy;
          end
        end
        StDivZero: begin
          result_q <= '0;
          ready_q  <= 1'b1;
          state_q  <= StDone;
        end
        StBusy: begin
          if (annul_i || !start_i) begin
            cnt_q   <= '0;
            state_q <= StIdle;
          end else begin
            part_q <= part_next;
            cnt_q  <= cnt_q + CntW'(1);
            if (cnt_q == CntW'(DIV_CYCLES - 1)) begin
              result_q <= {rem_fix, quot_fix};
              ready_q  <= 1'b1;
              state_q  <= StDone;
            end
          end
        end
        StDone: begin
          if (annul_i || !start_i) begin
            result_q <= '0;
            ready_q  <= 1'b0;
            state_q  <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed-vector bench for div_unit: latency, signed/unsigned results,
// divide-by-zero, annul and asynchronous reset behaviour.
module tb_div_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        signed_div;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic        annul;
  logic [63:0] result;
  logic        ready;

  int checks;
  int errors;

  div_unit #(
    .WIDTH(32)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start),
    .signed_div_i(signed_div),
    .opdata1_i   (opdata1),
    .opdata2_i   (opdata2),
    .annul_i     (annul),
    .result_o    (result),
    .ready_o     (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called just after an edge; that cycle is T. Operands are scrambled after
  // acceptance to show they are not re-sampled.
  task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp, input int lat);
    signed_div = sgn;
    opdata1    = a;
    opdata2    = b;
    start      = 1'b1;
    @(posedge clk); #1;
    opdata1    = $urandom;
    opdata2    = $urandom;
    signed_div = ~sgn;
    repeat (lat - 2) @(posedge clk);
    #1;
    check({tag, "_early"}, {63'd0, ready}, 64'd0);
    @(posedge clk); #1;
    check({tag, "_ready"}, {63'd0, ready}, 64'd1);
    check({tag, "_result"}, result, exp);
    start = 1'b0;
    @(posedge clk); #1;
    check({tag, "_drop_ready"}, {63'd0, ready}, 64'd0);
    check({tag, "_drop_result"}, result, 64'd0);
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst_n      = 1'b0;
    start      = 1'b0;
    signed_div = 1'b0;
    opdata1    = '0;
    opdata2    = '0;
    annul      = 1'b0;
    #12;
    check("reset_ready", {63'd0, ready}, 64'd0);
    check("reset_result", result, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_div("divu_100_7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33);
    run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'h2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33);
    run_div("div_7_m2", 1'b1, 32'h7, 32'hFFFF_FFFE, {32'h0000_0001, 32'hFFFF_FFFD}, 33);
    run_div("div_m100_m7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9,
            {32'hFFFF_FFFE, 32'h0000_000E}, 33);
    run_div("divu_fff9_2", 1'b0, 32'hFFFF_FFF9, 32'h2, {32'h1, 32'h7FFF_FFFC}, 33);
    run_div("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 33);
    run_div("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'h1, {32'h0, 32'hFFFF_FFFF}, 33);
    run_div("divu_5_0", 1'b0, 32'd5, 32'd0, 64'h0, 2);

    // Annul at T+10; new request accepted at T+11.
    signed_div = 1'b0;
    opdata1    = 32'd100;
    opdata2    = 32'd7;
    start      = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    annul = 1'b1;
    @(posedge clk); #1;
    annul = 1'b0;
    check("annul_no_ready", {63'd0, ready}, 64'd0);
    run_div("annul_then_9_3", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33);

    // Annul in DONE clears outputs, then annul in IDLE blocks acceptance of a
    // divide-by-zero that would otherwise show ready two edges later.
    signed_div = 1'b0;
    opdata1    = 32'd5;
    opdata2    = 32'd0;
    start      = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("done_ready", {63'd0, ready}, 64'd1);
    annul = 1'b1;
    @(posedge clk); #1;
    check("done_annul_ready", {63'd0, ready}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    check("idle_annul_blocks", {63'd0, ready}, 64'd0);
    annul = 1'b0;
    start = 1'b0;
    @(posedge clk); #1;

    // Asynchronous reset mid-BUSY.
    signed_div = 1'b0;
    opdata1    = 32'd100;
    opdata2    = 32'd7;
    start      = 1'b1;
    repeat (15) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_busy_ready", {63'd0, ready}, 64'd0);
    check("rst_busy_result", result, 64'd0);
    start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_div("after_rst_1000_9", 1'b0, 32'd1000, 32'd9, {32'd1, 32'd111}, 33);

    // Asynchronous reset while DONE holds a nonzero result.
    signed_div = 1'b0;
    opdata1    = 32'd50;
    opdata2    = 32'd3;
    start      = 1'b1;
    repeat (33) @(posedge clk);
    #1;
    check("pre_rst_result", result, {32'd2, 32'd16});
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_done_ready", {63'd0, ready}, 64'd0);
    check("rst_done_result", result, 64'd0);
    start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_div("after_rst_div_m9_4", 1'b1, 32'hFFFF_FFF7, 32'd4,
            {32'hFFFF_FFFF, 32'hFFFF_FFFE}, 33);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
